spi_bus_arbiter: RTL and testbench

Shares the board's single SPI master pin set (SCK/MOSI/MISO) between up to NUM_REQ SPI client engines: OLED, uSD, ADC, APP flash and DES. It uses round-robin arbitration and owns every chip select. It guarantees CS setup and hold times around each ownership period and a guard gap between owners. It sits between the core-side SPI engines and the top-level pads.

---
 rtl/spi_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI pads and every chip select; SETUP/HOLD/GUARD delays frame each owner.
// Latency: grant 1 cycle after IDLE sample, ready CS_SETUP later; no preemption, losers wait for IDLE.
module spi_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GUARD    = 1,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               ready,
    output logic               busy,
    input  logic [NUM_REQ-1:0] m_sck,
    input  logic [NUM_REQ-1:0] m_mosi,
    output logic               m_miso,
    output logic [NUM_REQ-1:0] cs_n,
    output logic               spi_sck,
    output logic               spi_mosi,
    input  logic               spi_miso
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACTIVE, S_HOLD, S_GUARD} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            own_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            cs_n_q  <= '1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            cs_n_q  <= cs_n_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // First requester at or after ptr, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        cs_n_d  = cs_n_q;
        ready_d = ready_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_SETUP;
                    own_d   = win_idx;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    cs_n_d  = ~(NUM_REQ'(1) << win_idx);
                    ptr_d   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    cnt_d   = CNT_W'(CS_SETUP - 1);
                end
            end
            S_SETUP: begin
                // A dropped request aborts before ready can rise.
                if (!req[own_q]) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_W'(CS_HOLD - 1);
                end else if (cnt_q == '0) begin
                    state_d = S_ACTIVE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACTIVE: begin
                if (!req[own_q]) begin
                    state_d = S_HOLD;
                    ready_d = 1'b0;
                    cnt_d   = CNT_W'(CS_HOLD - 1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_GUARD;
                    gnt_d   = '0;
                    cs_n_d  = '1;
                    cnt_d   = CNT_W'(GUARD - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                cs_n_d  = '1;
                ready_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        spi_sck  = 1'b0;
        spi_mosi = 1'b1;
        if (state_q == S_ACTIVE) begin
            spi_sck  = m_sck[own_q];
            spi_mosi = m_mosi[own_q];
        end
    end

    assign m_miso = spi_miso;
    assign gnt    = gnt_q;
    assign cs_n   = cs_n_q;
    assign ready  = ready_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed scenarios plus random requests, scored against a
// timestamp-based model (grant edge, release edge) of the owner's lifetime.
module tb_spi_bus_arbiter;
    localparam int N        = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int GUARD    = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] m_sck = '0;
    logic [N-1:0] m_mosi = '1;
    logic         spi_miso = 1'b0;
    logic [N-1:0] gnt, cs_n;
    logic         ready, busy, m_miso, spi_sck, spi_mosi;

    spi_bus_arbiter #(
        .NUM_REQ(N), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GUARD(GUARD), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .ready(ready), .busy(busy),
        .m_sck(m_sck), .m_mosi(m_mosi), .m_miso(m_miso), .cs_n(cs_n),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int m_own = 0, m_ptr = 0, m_g = -1, m_f = -1, last_rise = -1;
    logic [N-1:0] prev_cs_n = '1;
    logic [N-1:0] prev_gnt = '0;
    bit rand_pads = 1'b0;
    int gq[$];
    int exp_rr[6] = '{0, 1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        int r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One clock: advance the model on the sampled inputs, then score every output.
    task automatic step();
        logic [N-1:0] g_exp, cs_exp;
        logic rdy_exp, busy_exp;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_ptr = 0; m_g = -1; m_f = -1; m_own = 0; last_rise = -1;
        end else if (m_g < 0 || (m_f >= 0 && cyc > m_f + CS_HOLD + GUARD)) begin
            m_g = -1;
            for (int k = 0; k < N; k++) begin
                int i = (m_ptr + k) % N;
                if (m_g < 0 && req[i]) begin
                    m_g = cyc; m_f = -1; m_own = i;
                end
            end
            if (m_g >= 0) m_ptr = (m_own + 1) % N;
        end else if (m_f < 0 && !req[m_own]) begin
            m_f = cyc;
        end
        g_exp    = (m_g >= 0 && (m_f < 0 || cyc < m_f + CS_HOLD)) ? (N'(1) << m_own) : '0;
        cs_exp   = ~g_exp;
        rdy_exp  = (m_g >= 0 && m_f < 0 && cyc >= m_g + CS_SETUP);
        busy_exp = (m_g >= 0 && (m_f < 0 || cyc < m_f + CS_HOLD + GUARD));
        #1;
        chk("gnt", gnt, g_exp);
        chk("cs_n", cs_n, cs_exp);
        chk("ready", ready, rdy_exp);
        chk("busy", busy, busy_exp);
        chk("spi_sck", spi_sck, rdy_exp ? m_sck[m_own] : 1'b0);
        chk("spi_mosi", spi_mosi, rdy_exp ? m_mosi[m_own] : 1'b1);
        chk("m_miso", m_miso, spi_miso);
        if (!rst) begin
            chk("one_cs_low", $countones(~cs_n) <= 1, 1);
            chk("gnt_onehot0", $onehot0(gnt), 1);
            if ((prev_cs_n & ~cs_n) != 0 && last_rise >= 0)
                chk("guard_gap", (cyc - last_rise) >= GUARD + 1, 1);
            if ((~prev_cs_n & cs_n) != 0) last_rise = cyc;
        end
        if (gnt != 0 && prev_gnt == 0) gq.push_back(idx_of(gnt));
        prev_cs_n = cs_n;
        prev_gnt  = gnt;
        if (rand_pads) begin
            m_sck    = N'($urandom);
            m_mosi   = N'($urandom);
            spi_miso = 1'($urandom);
        end
    endtask

    task automatic wait_ready(input int budget);
        int k = 0;
        while (!ready && k < budget) begin step(); k++; end
        if (!ready) chk("wait_ready_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin step(); k++; end
        if (busy) chk("wait_idle_timeout", 0, 1);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        rst = 1'b1;
        step(); step();
        chk("rst_gnt", gnt, 0);
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mosi", spi_mosi, 1);

        // Single owner with toggling pad inputs
        rst = 1'b0; rand_pads = 1'b1; req = 4'b0010;
        step();
        chk("s1_gnt_e1", gnt, 4'b0010);
        chk("s1_cs_e1", cs_n, 4'b1101);
        chk("s1_busy_e1", busy, 1);
        step(); step();
        chk("s1_ready_e3", ready, 1);
        repeat (6) step();
        req = '0;
        step();
        chk("s1_ready_e10", ready, 0);
        step(); step();
        chk("s1_cs_e12", cs_n, 4'hF);
        chk("s1_gnt_e12", gnt, 0);
        step();
        chk("s1_idle_e13", busy, 0);

        // Round robin with all requesting
        rst = 1'b1; step(); rst = 1'b0;
        gq.delete();
        req = '1;
        for (int t = 0; t < 6; t++) begin
            wait_ready(20);
            repeat (3) step();
            req[idx_of(gnt)] = 1'b0;
            step();
            req = '1;
        end
        req = '0;
        wait_idle(20);
        chk("rr_count", gq.size() >= 6, 1);
        for (int t = 0; t < 6 && t < gq.size(); t++) chk("rr_order", gq[t], exp_rr[t]);

        // Pointer at 1, requests 0 and 3: index 3 wins
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0001;
        wait_ready(20);
        req = '0;
        step();
        wait_idle(20);
        req = 4'b1001;
        step();
        chk("rr_ptr1", gnt, 4'b1000);
        req = '0;
        wait_idle(20);

        // Abort during SETUP
        req = 4'b0100;
        step();
        chk("ab_gnt", gnt, 4'b0100);
        req = '0;
        step();
        chk("ab_ready_g1", ready, 0);
        step();
        chk("ab_cs_lo", cs_n, 4'b1011);
        chk("ab_ready_g2", ready, 0);
        step();
        chk("ab_cs_hi", cs_n, 4'hF);
        wait_idle(20);

        // Isolation: owner 0 active, requester 1 toggles its pins every cycle
        rand_pads = 1'b0; spi_miso = 1'b1;
        req = 4'b0001;
        wait_ready(20);
        for (int t = 0; t < 8; t++) begin
            m_sck[1]  = ~m_sck[1];
            m_mosi[1] = ~m_mosi[1];
            m_sck[0]  = 1'($urandom);
            m_mosi[0] = 1'($urandom);
            #1;
            chk("iso_sck", spi_sck, m_sck[0]);
            chk("iso_mosi", spi_mosi, m_mosi[0]);
            chk("iso_miso", m_miso, 1);
            step();
        end
        req = '0;
        for (int t = 0; t < 5; t++) begin
            m_sck[1] = ~m_sck[1]; m_sck[0] = ~m_sck[0];
            m_mosi[1] = ~m_mosi[1]; m_mosi[0] = ~m_mosi[0];
            step();
        end

        // Reset while owner 2 is active
        req = 4'b0100;
        wait_ready(30);
        step();
        m_sck = '1;
        rst = 1'b1; req = '1;
        step();
        chk("mid_rst_cs", cs_n, 4'hF);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sck", spi_sck, 0);
        rst = 1'b0;
        step();
        chk("post_rst_gnt", gnt, 4'b0001);
        req = '0;
        wait_idle(20);

        // Random requests with sticky bits
        rand_pads = 1'b1;
        for (int t = 0; t < 10000; t++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
